// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The two macros mirror the definitions in common.vh that decode also uses.
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package fetch_unit_pkg;
  localparam int          INST_W   = `INST_WIDTH;
  localparam logic [31:0] NOP_INST = `NOP_INSTRUCTION;

  typedef struct packed {
    logic [31:0]       addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/fetch_inst_fifo.sv
// Synchronous DEPTH-entry FIFO of {addr, inst}; flush wins over push and pop.
module fetch_inst_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, credit-limited imem requests, response FIFO and decode output register.
// Optional macro FETCH_PERF_COUNTER_EN adds perf_fetch_count / perf_stall_count outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_signal_from_execute_stage,
  input  logic [31:0]       branch_target_from_execute_stage,
  input  logic              stall_pipeline_signal_decode_stage,
  fetch_unit_if.master      imem,
  output logic [INST_W-1:0] inst_for_decode_stage,
  output logic [31:0]       inst_addr_for_decode_stage
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]       perf_fetch_count,
  output logic [31:0]       perf_stall_count
`endif
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic [31:0]       r_pc;
  logic [31:0]       r_resp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [INST_W-1:0] r_inst_p1;
  logic [31:0]       r_inst_addr_p1;

  logic              w_branch;
  logic              w_stall;
  logic [CW:0]       w_inflight;
  logic              w_credit_ok;
  logic              w_fire;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_branch    = branch_signal_from_execute_stage;
  assign w_stall     = stall_pipeline_signal_decode_stage;

  // Outstanding requests plus buffered entries never exceed the FIFO depth.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_credit_ok = w_inflight < (CW+1)'(IBUF_DEPTH);

  assign imem.imem_req_valid = !rst && !w_branch && w_credit_ok;
  assign imem.imem_req_addr  = r_pc;

  assign w_fire      = imem.imem_req_valid && imem.imem_req_ready;
  assign w_resp      = imem.imem_resp_valid;
  assign w_push      = w_resp && !w_branch && (r_drop_cnt == '0);
  assign w_pop       = !w_branch && !w_stall && !w_empty;
  assign w_push_data = '{addr: r_resp_pc, inst: imem.imem_resp_data};

  fetch_inst_fifo #(.DEPTH(IBUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_branch),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_resp);
      if (w_branch) begin
        r_pc       <= branch_target_from_execute_stage;
        r_resp_pc  <= branch_target_from_execute_stage;
        // Every request still in flight after this cycle belongs to the old stream.
        r_drop_cnt <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_fire) r_pc <= pc_inc(r_pc);
        if (w_push) r_resp_pc <= pc_inc(r_resp_pc);
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // p1: decode-facing output register; empty slots present as NOP at address 0.
  always_ff @(posedge clk) begin
    if (rst || w_branch) begin
      r_inst_p1      <= NOP_INST;
      r_inst_addr_p1 <= '0;
    end else if (!w_stall) begin
      if (!w_empty) begin
        r_inst_p1      <= w_head.inst;
        r_inst_addr_p1 <= w_head.addr;
      end else begin
        r_inst_p1      <= NOP_INST;
        r_inst_addr_p1 <= '0;
      end
    end
  end

  assign inst_for_decode_stage      = r_inst_p1;
  assign inst_addr_for_decode_stage = r_inst_addr_p1;

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_stall && !w_branch) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_count = r_perf_fetch;
  assign perf_stall_count = r_perf_stall;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, variable-latency imem model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] perf_f;
  logic [31:0] perf_s;
`endif

  logic        m_ready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  fetch_unit_if imem_if();
  assign imem_if.imem_req_ready  = m_ready;
  assign imem_if.imem_resp_valid = m_rvalid;
  assign imem_if.imem_resp_data  = m_rdata;

  fetch_unit #(.RESET_PC(32'h0), .IBUF_DEPTH(4)) dut (
    .clk                                (clk),
    .rst                                (rst),
    .branch_signal_from_execute_stage   (br),
    .branch_target_from_execute_stage   (tgt),
    .stall_pipeline_signal_decode_stage (stall),
    .imem                               (imem_if),
    .inst_for_decode_stage              (out_inst),
    .inst_addr_for_decode_stage         (out_addr)
`ifdef FETCH_PERF_COUNTER_EN
    ,
    .perf_fetch_count                   (perf_f),
    .perf_stall_count                   (perf_s)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // imem model
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  int          lat = 1;
  int          limit = 0;
  int          accepted = 0;
  int          cyc = 0;
  bit          ready_en = 1'b1;
  logic [31:0] acc_log [128];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 | a;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
    end
    m_ready = ready_en && (accepted < limit);
    if (imem_if.imem_req_valid && m_ready) begin
      if (accepted < 128) acc_log[accepted] = imem_if.imem_req_addr;
      pend.push_back('{imem_if.imem_req_addr, cyc + lat});
      accepted++;
    end
  end

  // scoreboard
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] prev_inst = NOP;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] ea, ei;
  logic        mon_s, mon_b, mon_r;
  int          edge_n = 0;
  int          n_deliv = 0;
  int          n_stall_cyc = 0;
  int          max_fifo = 0;
  int          deliv_n [4];

  task automatic expect_inst(input logic [31:0] a, input logic [31:0] i);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(i);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mon_s = stall;
      mon_b = br;
      mon_r = rst;
      #1;
      if (!mon_r) begin
        edge_n++;
        if (int'(dut.u_fifo.o_count) > max_fifo) max_fifo = int'(dut.u_fifo.o_count);
        if (mon_b) begin
          check("branch_out_inst", out_inst, NOP);
          check("branch_out_addr", out_addr, 32'h0);
        end else if (mon_s) begin
          n_stall_cyc++;
          check("stall_hold_inst", out_inst, prev_inst);
          check("stall_hold_addr", out_addr, prev_addr);
        end else if (out_inst == NOP) begin
          check("empty_slot_addr", out_addr, 32'h0);
        end else begin
          if (n_deliv < 4) deliv_n[n_deliv] = edge_n;
          n_deliv++;
          if (exp_addr_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_inst: got addr 0x%08h, expected none", out_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            ei = exp_inst_q.pop_front();
            check("deliv_addr", out_addr, ea);
            check("deliv_inst", out_inst, ei);
          end
        end
      end
      prev_inst = out_inst;
      prev_addr = out_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out_addr(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (out_inst != NOP && out_addr == a) found = 1'b1;
    end
    check(name, 32'(found), 32'h1);
  endtask

  task automatic wait_accepted(input int n, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (accepted >= n) found = 1'b1;
    end
    check(name, 32'(found), 32'h1);
  endtask

  task automatic wait_drain(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (exp_addr_q.size() == 0 && pend.size() == 0 && out_inst == NOP) found = 1'b1;
    end
    check(name, 32'(found), 32'h1);
  endtask

  int idx_c;

  initial begin
    repeat (3) tick();
    check("rst_out_inst", out_inst, NOP);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_req_valid", 32'(imem_if.imem_req_valid), 32'h0);

    // sequential stream from reset, 2-cycle stall while 0x8 is presented
    lat = 1;
    limit = 8;
    for (int i = 0; i < 8; i++) expect_inst(32'(i * 4), 32'hE000_0000 | 32'(i * 4));
    rst = 1'b0;
    wait_out_addr(32'h8, "wait_out_0x8");
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    wait_drain("drain_a");
    check("fill_first_edge", 32'(deliv_n[0]), 32'd3);
    check("fill_second_edge", 32'(deliv_n[1]), 32'd4);
    check("fill_third_edge", 32'(deliv_n[2]), 32'd5);
    check("after_stall_edge", 32'(deliv_n[3]), 32'd8);

    // branch to 0x100 with three requests outstanding
    lat = 4;
    limit = 11;
    wait_accepted(11, "wait_three_outstanding");
    br = 1'b1;
    tgt = 32'h100;
    limit = 15;
    expect_inst(32'h100, 32'hE000_0100);
    expect_inst(32'h104, 32'hE000_0104);
    expect_inst(32'h108, 32'hE000_0108);
    expect_inst(32'h10C, 32'hE000_010C);
    tick();
    br = 1'b0;
    wait_drain("drain_b");
    check("req_addr_8", acc_log[8], 32'h20);
    check("req_addr_10", acc_log[10], 32'h28);
    check("req_after_branch", acc_log[11], 32'h100);
    check("req_after_branch_4", acc_log[14], 32'h10C);

    // branch and stall in the same cycle
    lat = 1;
    limit = accepted + 20;
    expect_inst(32'h110, 32'hE000_0110);
    expect_inst(32'h114, 32'hE000_0114);
    expect_inst(32'h118, 32'hE000_0118);
    wait_out_addr(32'h118, "wait_out_0x118");
    br = 1'b1;
    stall = 1'b1;
    tgt = 32'h200;
    idx_c = accepted;
    limit = idx_c + 4;
    for (int i = 0; i < 4; i++) expect_inst(32'h200 + 32'(i * 4), 32'hE000_0200 + 32'(i * 4));
    tick();
    br = 1'b0;
    stall = 1'b0;
    wait_drain("drain_c");
    check("req_after_br_stall", acc_log[idx_c], 32'h200);
    check("req_after_br_stall_3", acc_log[idx_c + 3], 32'h20C);

    // imem not ready for 5 cycles
    lat = 1;
    limit = accepted + 10;
    for (int i = 0; i < 10; i++) expect_inst(32'h210 + 32'(i * 4), 32'hE000_0210 + 32'(i * 4));
    wait_out_addr(32'h214, "wait_out_0x214");
    ready_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("notready_req_valid", 32'(imem_if.imem_req_valid), 32'h1);
      check("notready_req_addr", imem_if.imem_req_addr, 32'h220);
    end
    check("notready_drained_inst", out_inst, NOP);
    check("notready_drained_addr", out_addr, 32'h0);
    ready_en = 1'b1;
    wait_drain("drain_d");

    check("exp_queue_empty", 32'(exp_addr_q.size()), 32'h0);
    check("fifo_max_le_depth", 32'(max_fifo <= 4), 32'h1);
    check("deliv_total", 32'(n_deliv), 32'd29);
`ifdef FETCH_PERF_COUNTER_EN
    check("perf_fetch_count", perf_f, 32'(n_deliv));
    check("perf_stall_count", perf_s, 32'(n_stall_cyc));
    check("perf_stall_count_abs", perf_s, 32'd2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode_unit.
- Owns the PC, issues sequential word fetches to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO.
- Presents one instruction plus its address per cycle to decode; holds it on decode stall; flushes and redirects on an execute-stage branch.
- Decode has no valid bit, so an empty fetch slot is always presented as `NOP_INSTRUCTION`.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- IBUF_DEPTH, 4, instruction FIFO depth. Also the credit limit on outstanding requests plus buffered entries. Power of 2, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- branch_signal_from_execute_stage  in  1  redirect/flush request
- branch_target_from_execute_stage  in  32  redirect PC, word aligned
- stall_pipeline_signal_decode_stage  in  1  decode load-use stall; hold output
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_resp_valid  in  1  response valid; in order, ≥1 cycle after accept, no backpressure
- imem_resp_data  in  32  instruction word
- inst_for_decode_stage  out  32  instruction to decode
- inst_addr_for_decode_stage  out  32  address of that instruction

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0, drop_cnt=0.
  - inst_for_decode_stage=`NOP_INSTRUCTION`, inst_addr_for_decode_stage=0, imem_req_valid=0.
- Request issue:
  - imem_req_valid = !rst && !branch && (outstanding + fifo_count < IBUF_DEPTH).
  - imem_req_addr = pc.
  - On fire (valid&&ready): pc += 4, outstanding += 1.
  - Valid may drop without fire only when branch asserts or credit runs out.
- Response handling, when imem_resp_valid is high:
  - outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and discard the response.
  - Otherwise: push {resp_pc, imem_resp_data} into the FIFO and resp_pc += 4.
  - Credit guarantees the FIFO never overflows. An overflow is an assertion failure.
- Output register, updated every cycle:
  - branch=1: load NOP / addr 0. Branch wins over stall.
  - stall=1: hold current value; no FIFO pop.
  - Otherwise, FIFO non-empty: pop head into the output register.
  - Otherwise, FIFO empty: load NOP / addr 0.
  - A response pushed in cycle N is poppable at the earliest in cycle N+1. No bypass.
- Redirect (branch=1) in cycle N:
  - pc <= target, resp_pc <= target.
  - FIFO cleared.
  - drop_cnt <= outstanding − (imem_resp_valid ? 1 : 0). No request fires in a branch cycle.
  - A response arriving in cycle N is discarded.
  - First request for the target is issued in cycle N+1.
- Back-to-back branches: each later branch supersedes the earlier one.
  - drop_cnt is recomputed from the current outstanding count, which already covers stale requests.
- Steady state, 1-cycle memory, no stalls: one instruction per cycle after 3 cycles of fill latency from reset release.
- Counters: outstanding and drop_cnt are $clog2(IBUF_DEPTH)+1 bits wide. PC wraps modulo 2^32.

Optional Feature:
- Macro: FETCH_PERF_COUNTER_EN.
- Defined: adds output ports perf_fetch_count[31:0] and perf_stall_count[31:0].
  - perf_fetch_count increments on every FIFO pop into the output register.
  - perf_stall_count increments on every cycle with stall=1 and branch=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- common.vh holds `NOP_INSTRUCTION` (32'h0000_0013), already shared with decode, plus a new `INST_WIDTH` (32).
- One sub-module, fetch_inst_fifo:
  - Synchronous, IBUF_DEPTH×64-bit (addr+inst).
  - push, pop, flush, count, empty.
  - flush has priority over push/pop.
- fetch_unit holds the PC, credit/drop counters and the output register.

Test Plan:
- Reset release, 1-cycle memory, no stall, ready always high → imem_req_addr 0x0, 0x4, 0x8…; decode sees NOP for the first cycles, then addr 0x0, 0x4, 0x8 on consecutive cycles with matching data.
- Stall held 2 cycles while output is addr 0x8 → output stays 0x8 for both cycles, then 0xC; FIFO never exceeds 4 entries and requests pause at credit limit.
- Branch to 0x100 with 3 requests outstanding (memory latency 3) → next 3 responses discarded, output NOP until first response for 0x100 arrives, then 0x100, 0x104.
- Branch and stall asserted in the same cycle → output NOP/addr 0, and next fetch address is the target.
- imem_req_ready held low 5 cycles → imem_req_valid stays 1, imem_req_addr stable, pc does not advance, and output drains to NOP once the FIFO is empty.
- With FETCH_PERF_COUNTER_EN defined: 10 instructions delivered with 3 stall cycles → perf_fetch_count=10, perf_stall_count=3.
